// File: rtl/note_player.sv
// note_player: holds a latched note for a given number of beat ticks while play is high,
// then returns a one-cycle note_done pulse to the song controller.
module note_player #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              new_note,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [DUR_W-1:0]  duration_in,
    input  logic              beat,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_active,
    output logic [DUR_W-1:0]  elapsed,
    output logic              note_done
);
    typedef enum logic [1:0] {IDLE, PLAYING, PAUSED, DONE} state_t;
    state_t            state, state_nx;
    logic [DUR_W-1:0]  remaining, remaining_nx, elapsed_nx;
    logic [NOTE_W-1:0] note_nx;
    logic              active_nx;
    logic              last_beat;
    logic              audible;
    assign last_beat = remaining <= DUR_W'(1);
    assign audible   = note_out != '0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            note_out    <= '0;
            note_active <= 1'b0;
            elapsed     <= '0;
            remaining   <= '0;
            note_done   <= 1'b0;
        end else begin
            state       <= state_nx;
            note_out    <= note_nx;
            note_active <= active_nx;
            elapsed     <= elapsed_nx;
            remaining   <= remaining_nx;
            note_done   <= state == DONE;
        end
    end
    // A strobe reloads from any state; in DONE the pending pulse is still issued above.
    always_comb begin
        state_nx     = state;
        note_nx      = note_out;
        remaining_nx = remaining;
        elapsed_nx   = elapsed;
        active_nx    = 1'b0;
        if (new_note) begin
            note_nx      = note_in;
            remaining_nx = duration_in;
            elapsed_nx   = '0;
            state_nx     = duration_in == '0 ? DONE : play ? PLAYING : PAUSED;
            active_nx    = duration_in != '0 && play && note_in != '0;
        end else begin
            case (state)
                PLAYING: begin
                    if (!play) begin
                        state_nx = PAUSED;
                    end else if (beat) begin
                        remaining_nx = remaining == '0 ? remaining : remaining - DUR_W'(1);
                        elapsed_nx   = &elapsed ? elapsed : elapsed + DUR_W'(1);
                        state_nx     = last_beat ? DONE : PLAYING;
                        active_nx    = !last_beat && audible;
                    end else begin
                        active_nx = audible;
                    end
                end
                PAUSED: begin
                    state_nx  = play ? PLAYING : PAUSED;
                    active_nx = play && audible;
                end
                DONE:    state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end
endmodule

// File: tb/tb_note_player.sv
// tb_note_player: scenario and randomized checks of note_player against a note-level model.
module tb_note_player;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       play = 1'b0;
    logic       new_note = 1'b0;
    logic [5:0] note_in = '0;
    logic [5:0] duration_in = '0;
    logic       beat = 1'b0;
    logic [5:0] note_out;
    logic       note_active;
    logic [5:0] elapsed;
    logic       note_done;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;

    // Model: a note is "busy" while beats remain, "running" while beats are being counted.
    int m_note, m_left, m_el;
    bit m_busy, m_run, m_fin, m_done, m_active;

    note_player dut (
        .clk(clk), .reset(reset), .play(play), .new_note(new_note), .note_in(note_in),
        .duration_in(duration_in), .beat(beat), .note_out(note_out),
        .note_active(note_active), .elapsed(elapsed), .note_done(note_done)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        if (!reset) begin
            m_note = 0; m_left = 0; m_el = 0;
            m_busy = 0; m_run = 0; m_fin = 0; m_done = 0;
        end else begin
            m_done = m_fin;
            m_fin  = 0;
            if (new_note) begin
                m_note = note_in; m_left = duration_in; m_el = 0;
                m_busy = duration_in != 0;
                m_fin  = !m_busy;
                m_run  = m_busy && play;
            end else if (m_busy) begin
                if (m_run && !play) m_run = 0;
                else if (!m_run && play) m_run = 1;
                else if (m_run && beat) begin
                    m_left--; m_el++;
                    if (m_left == 0) begin m_busy = 0; m_run = 0; m_fin = 1; end
                end
            end
        end
        m_active = m_busy && m_run && m_note != 0;
    endtask

    task automatic tick(input bit nn, input int nt, input int dur, input bit pl, input bit bt);
        new_note = nn; note_in = 6'(nt); duration_in = 6'(dur); play = pl; beat = bt;
        model_step();
        @(posedge clk);
        #1;
        done_seen += int'(note_done);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick(0, 0, 0, 0, 0);
        tick(1, 5, 3, 1, 1);
        tests++;
        if ({note_out, note_active, elapsed, note_done} !== 14'd0) begin
            fails++;
            $display("FAIL reset: note_out=%0d active=%0b elapsed=%0d done=%0b, want all 0",
                     note_out, note_active, elapsed, note_done);
        end
        reset = 1'b1;
        tick(0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        done_seen = 0;
        tick(1, 20, 3, 1, 0);
        tests++;
        if (note_active !== 1'b1 || note_out !== 6'd20 || elapsed !== 6'd0) begin
            fails++;
            $display("FAIL basic_load: active=%0b note=%0d elapsed=%0d, want 1 20 0",
                     note_active, note_out, elapsed);
        end
        for (int b = 1; b <= 3; b++) begin
            repeat (9) tick(0, 0, 0, 1, 0);
            tick(0, 0, 0, 1, 1);
            tests++;
            if (elapsed !== 6'(b) || note_active !== (b < 3) || note_done !== 1'b0) begin
                fails++;
                $display("FAIL basic_beat%0d: elapsed=%0d active=%0b done=%0b, want %0d %0b 0",
                         b, elapsed, note_active, note_done, b, b < 3);
            end
        end
        tick(0, 0, 0, 1, 0);
        tests++;
        if (note_done !== 1'b1) begin
            fails++;
            $display("FAIL basic_done: note_done=%0b, want 1", note_done);
        end
        tick(0, 0, 0, 1, 0);
        tests++;
        if (note_done !== 1'b0 || done_seen != 1 || note_out !== 6'd20) begin
            fails++;
            $display("FAIL basic_single: done=%0b pulses=%0d note=%0d, want 0 1 20",
                     note_done, done_seen, note_out);
        end
    endtask

    task automatic test_zero_dur();
        bit act = 0;
        tick(1, 15, 0, 1, 0);
        act |= note_active;
        tests++;
        if (note_done !== 1'b0) begin
            fails++;
            $display("FAIL zero_edge1: note_done=%0b, want 0", note_done);
        end
        tick(0, 0, 0, 1, 0);
        act |= note_active;
        tests++;
        if (note_done !== 1'b1 || act) begin
            fails++;
            $display("FAIL zero_edge2: done=%0b active_seen=%0b, want 1 0", note_done, act);
        end
        tick(0, 0, 0, 1, 0);
    endtask

    task automatic test_rest();
        bit act = 0;
        tick(1, 0, 2, 1, 0);
        act |= note_active;
        for (int b = 0; b < 2; b++) begin
            repeat (3) begin tick(0, 0, 0, 1, 0); act |= note_active; end
            tick(0, 0, 0, 1, 1);
            act |= note_active;
        end
        tick(0, 0, 0, 1, 0);
        tests++;
        if (note_done !== 1'b1 || act || elapsed !== 6'd2) begin
            fails++;
            $display("FAIL rest: done=%0b active_seen=%0b elapsed=%0d, want 1 0 2",
                     note_done, act, elapsed);
        end
    endtask

    task automatic test_pause();
        done_seen = 0;
        tick(1, 33, 4, 1, 0);
        repeat (2) begin tick(0, 0, 0, 1, 1); tick(0, 0, 0, 1, 0); end
        tick(0, 0, 0, 0, 0);
        repeat (3) begin tick(0, 0, 0, 0, 1); tick(0, 0, 0, 0, 0); end
        tests++;
        if (elapsed !== 6'd2 || note_active !== 1'b0 || done_seen != 0) begin
            fails++;
            $display("FAIL pause_hold: elapsed=%0d active=%0b pulses=%0d, want 2 0 0",
                     elapsed, note_active, done_seen);
        end
        tick(0, 0, 0, 1, 0);
        tests++;
        if (note_active !== 1'b1) begin
            fails++;
            $display("FAIL pause_resume: active=%0b, want 1", note_active);
        end
        tick(0, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 0);
        tests++;
        if (elapsed !== 6'd3 || done_seen != 0) begin
            fails++;
            $display("FAIL pause_beat3: elapsed=%0d pulses=%0d, want 3 0", elapsed, done_seen);
        end
        tick(0, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 0);
        tests++;
        if (note_done !== 1'b1 || elapsed !== 6'd4) begin
            fails++;
            $display("FAIL pause_done: done=%0b elapsed=%0d, want 1 4", note_done, elapsed);
        end
    endtask

    task automatic test_back_to_back();
        done_seen = 0;
        tick(1, 7, 3, 1, 0);
        tick(0, 0, 0, 1, 1);
        tick(1, 9, 5, 1, 1);
        tests++;
        if (elapsed !== 6'd0 || note_out !== 6'd9 || note_active !== 1'b1) begin
            fails++;
            $display("FAIL abort_load: elapsed=%0d note=%0d active=%0b, want 0 9 1",
                     elapsed, note_out, note_active);
        end
        for (int b = 0; b < 5; b++) begin tick(0, 0, 0, 1, 0); tick(0, 0, 0, 1, 1); end
        tests++;
        if (done_seen != 0 || elapsed !== 6'd5) begin
            fails++;
            $display("FAIL abort_count: pulses=%0d elapsed=%0d, want 0 5", done_seen, elapsed);
        end
        tick(0, 0, 0, 1, 0);
        tests++;
        if (note_done !== 1'b1 || done_seen != 1) begin
            fails++;
            $display("FAIL abort_done: done=%0b pulses=%0d, want 1 1", note_done, done_seen);
        end
    endtask

    task automatic test_reset_mid();
        done_seen = 0;
        tick(1, 12, 4, 1, 0);
        tick(0, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 0);
        reset = 1'b0;
        tick(0, 0, 0, 1, 1);
        tests++;
        if ({note_out, note_active, elapsed, note_done} !== 14'd0) begin
            fails++;
            $display("FAIL reset_mid: note=%0d active=%0b elapsed=%0d done=%0b, want all 0",
                     note_out, note_active, elapsed, note_done);
        end
        tick(0, 0, 0, 1, 1);
        reset = 1'b1;
        repeat (6) tick(0, 0, 0, 1, 1);
        tick(1, 5, 1, 1, 0);
        tick(0, 0, 0, 1, 1);
        tick(0, 0, 0, 1, 0);
        tests++;
        if (note_done !== 1'b1 || done_seen != 1 || note_out !== 6'd5) begin
            fails++;
            $display("FAIL reset_resume: done=%0b pulses=%0d note=%0d, want 1 1 5",
                     note_done, done_seen, note_out);
        end
    endtask

    task automatic test_random();
        bit pl = 1;
        for (int c = 0; c < 3000; c++) begin
            bit nn = $urandom_range(0, 11) == 0;
            if ($urandom_range(0, 15) == 0) pl = !pl;
            reset = $urandom_range(0, 199) != 0;
            tick(nn, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63),
                 ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6), pl,
                 $urandom_range(0, 2) == 0);
            tests++;
            if (note_out !== 6'(m_note) || note_active !== m_active ||
                elapsed !== 6'(m_el) || note_done !== m_done) begin
                fails++;
                $display("FAIL random c=%0d: got note=%0d act=%0b el=%0d done=%0b, want %0d %0b %0d %0b",
                         c, note_out, note_active, elapsed, note_done,
                         m_note, m_active, m_el, m_done);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_dur();
        test_rest();
        test_pause();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/note_player.md
Name: note_player

Overview:
- Responder side of the note handshake. Accepts a one-cycle new_note strobe carrying a note code and a duration in beats.
- Holds the note on its output for that many beat ticks while play is high, then returns a one-cycle note_done pulse.
- Sits between the song reading controller (which issues new_note and waits for note_done) and the tone generator (which consumes note_out and note_active).

Parameters:
- NOTE_W, 6, width of note code; code 0 is a rest.
- DUR_W, 6, width of duration field, in beats.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- play  input  1  level; high = playing, low = paused.
- new_note  input  1  one-cycle strobe; note_in and duration_in valid this cycle.
- note_in  input  NOTE_W  note code to play.
- duration_in  input  DUR_W  note length in beats.
- beat  input  1  one-cycle tick from beat generator (e.g. 48 Hz).
- note_out  output  NOTE_W  latched note code for the tone generator.
- note_active  output  1  high while a non-rest note is sounding.
- elapsed  output  DUR_W  beats consumed of current note.
- note_done  output  1  one-cycle pulse when the current note completes.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE.
  - note_out=0, note_active=0, elapsed=0, note_done=0.
  - Internal remaining-beat counter cleared.
  - Reset overrides every other input, including mid-note; no note_done is produced for an interrupted note.
- States: IDLE, PLAYING, PAUSED, DONE. Registered outputs only.
- IDLE:
  - note_active=0.
  - On new_note: latch note_in to note_out, load remaining=duration_in, clear elapsed.
  - If duration_in==0: go to DONE.
  - Else if play: go to PLAYING, else go to PAUSED.
  - note_active rises the cycle after new_note, only if note_in!=0 and play is high.
- PLAYING:
  - note_active = (note_out!=0).
  - On beat: remaining decrements and elapsed increments. Both saturate; there is no wrap.
  - beat with remaining==1: go to DONE and drop note_active on that same edge.
  - play==0 without beat: go to PAUSED, note_active=0, counters held.
  - play==0 together with beat: the beat is ignored and the state goes to PAUSED.
- PAUSED:
  - note_active=0; beat is ignored.
  - play==1: go to PLAYING; note_active returns the following cycle.
- DONE:
  - note_done=1 for exactly one cycle, then IDLE.
  - note_out holds its last value until the next new_note.
- new_note in PLAYING or PAUSED:
  - Aborts the current note and reloads from the new inputs, with the same rules as IDLE.
  - No note_done is produced for the aborted note.
  - new_note wins over a simultaneous beat.
- new_note in DONE: the note_done pulse still completes; the strobe is then processed as if received in IDLE on that same edge, so DONE goes straight to the load.
- Latency: a note of N beats (N>=1) sees note_done assert on the clk edge after the Nth beat tick is sampled in PLAYING.
- The controller's two-cycle gap (NEXT_NOTE then NEW_NOTE) guarantees new_note never coincides with note_done from the same note.

Test Plan:
- Reset, then new_note with note_in=6'd20, duration_in=3, play=1, beats every 10 cycles:
  - note_active=1 one cycle after new_note.
  - elapsed steps 1,2,3.
  - Single note_done one cycle after the 3rd beat; note_active=0 on that edge.
- new_note with duration_in=0:
  - note_done pulses on the second edge after the strobe.
  - note_active never rises.
- note_in=0 (rest), duration_in=2:
  - note_active stays 0.
  - note_done follows the 2nd beat.
- Note of duration 4; drop play after beat 2, send 3 beats while paused, restore play:
  - elapsed holds at 2 while paused.
  - note_done only after 2 further beats.
- new_note(note=9, dur=5) mid-note after beat 1 of a dur=3 note, with beat asserted the same cycle:
  - No note_done for the first note.
  - elapsed=0, note_out=9; done after 5 more beats.
- Assert reset low at beat 2 of a dur=4 note:
  - All outputs are 0 next edge and note_done is never pulsed.
  - Deassert reset, send a new note: normal operation resumes.
